// File: rtl/snake_pkg.sv
// Shared encodings for the snake game blocks: grid geometry, directions, FSM states.
// The direction encoding is also used by the keyboard block.
package snake_pkg;

  localparam int GRID_W  = 40;
  localparam int GRID_H  = 30;
  localparam int COORD_W = 6;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  // Opposite pairs share bit 1 and differ only in bit 0.
  function automatic logic is_opposite(input dir_t a, input dir_t b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Step-rate generator: counts 0..TICK_CYCLES-1 while run is high and pulses
// move_tick combinationally in the wrap cycle. Also used by the renderer blink logic.
module snake_tick_gen #(
  parameter int TICK_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic move_tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] count;

  assign move_tick = run && (count == LAST);

  // The counter parks at zero whenever the game is not running.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (!run || move_tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/snake_body_mover.sv
// Snake movement, body storage, wall/self collision detection and renderer cell queries.
// Head is seg[0]; the body shifts one slot per move tick.
module snake_body_mover
  import snake_pkg::*;
#(
  parameter int MAX_LEN     = 16,
  parameter int INIT_LEN    = 3,
  parameter int INIT_X      = 10,
  parameter int INIT_Y      = 10,
  parameter int TICK_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       add_cube,
  input  logic [5:0] query_x,
  input  logic [5:0] query_y,
  output logic [5:0] head_x,
  output logic [5:0] head_y,
  output logic [4:0] body_len,
  output logic       move_tick,
  output logic       game_over,
  output logic       query_hit,
  output logic       query_head
);

  localparam logic [4:0] MAX_LEN_W = 5'(MAX_LEN);
  localparam coord_t     ONE       = coord_t'(1);

  coord_t     seg_x [MAX_LEN];
  coord_t     seg_y [MAX_LEN];
  logic [4:0] len_q;
  state_t     state_q, state_d;
  dir_t       dir_cur, dir_next, key_dir;
  logic       key_any, add_prev, grow_pending, add_edge, grow_now, grow_len;
  logic       run, tick, wall_hit, self_hit, collide, hit_d;
  logic [4:0] self_lim;
  coord_t     nx, ny;

  assign run = (state_q == ST_PLAY);

  snake_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .move_tick (tick)
  );

  assign move_tick = tick;
  assign game_over = (state_q == ST_DEAD);
  assign head_x    = seg_x[0];
  assign head_y    = seg_y[0];
  assign body_len  = len_q;

  assign key_any  = key_up | key_down | key_left | key_right;
  assign add_edge = add_cube & ~add_prev;
  assign grow_now = grow_pending | add_edge;
  assign grow_len = grow_now && (len_q < MAX_LEN_W);
  // A growing step keeps the tail in place, so the tail slot becomes illegal too.
  assign self_lim = grow_len ? len_q : len_q - 5'd1;

  always_comb begin
    key_dir = DIR_RIGHT;
    if (key_up)        key_dir = DIR_UP;
    else if (key_down) key_dir = DIR_DOWN;
    else if (key_left) key_dir = DIR_LEFT;
  end

  always_comb begin
    nx = seg_x[0];
    ny = seg_y[0];
    case (dir_next)
      DIR_UP:    ny = seg_y[0] - ONE;
      DIR_DOWN:  ny = seg_y[0] + ONE;
      DIR_LEFT:  nx = seg_x[0] - ONE;
      default:   nx = seg_x[0] + ONE;
    endcase
    wall_hit = (nx == '0) || (nx == coord_t'(GRID_W - 1)) ||
               (ny == '0) || (ny == coord_t'(GRID_H - 1));
    self_hit = 1'b0;
    for (int k = 1; k < MAX_LEN; k++) begin
      if ((5'(k) < self_lim) && (seg_x[k] == nx) && (seg_y[k] == ny)) self_hit = 1'b1;
    end
    collide = wall_hit | self_hit;
  end

  always_comb begin
    hit_d = 1'b0;
    for (int k = 1; k < MAX_LEN; k++) begin
      if ((5'(k) < len_q) && (seg_x[k] == query_x) && (seg_y[k] == query_y)) hit_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (key_any) state_d = ST_PLAY;
      ST_PLAY: if (tick && collide) state_d = ST_DEAD;
      default: state_d = ST_DEAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dir_cur      <= DIR_RIGHT;
      dir_next     <= DIR_RIGHT;
      add_prev     <= 1'b0;
      grow_pending <= 1'b0;
      len_q        <= 5'(INIT_LEN);
      query_hit    <= 1'b0;
      query_head   <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= (i < INIT_LEN) ? coord_t'(INIT_X - i) : '0;
        seg_y[i] <= (i < INIT_LEN) ? coord_t'(INIT_Y) : '0;
      end
    end else begin
      add_prev   <= add_cube;
      query_hit  <= hit_d;
      query_head <= (seg_x[0] == query_x) && (seg_y[0] == query_y);
      if (state_q != ST_DEAD) begin
        // In the tick cycle the latched request is what gets applied, so check against it.
        if (key_any && !is_opposite(key_dir, tick ? dir_next : dir_cur)) dir_next <= key_dir;
        if (tick) begin
          dir_cur      <= dir_next;
          grow_pending <= 1'b0;
          if (!collide) begin
            for (int i = 1; i < MAX_LEN; i++) begin
              seg_x[i] <= seg_x[i-1];
              seg_y[i] <= seg_y[i-1];
            end
            seg_x[0] <= nx;
            seg_y[0] <= ny;
            if (grow_len) len_q <= len_q + 5'd1;
          end
        end else if (add_edge) begin
          grow_pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/snake_body_mover.md
Name: snake_body_mover

Overview:
- Upstream neighbour of the apple-eating stage: owns snake movement and body storage.
- Produces head_x/head_y for the apple checker and consumes its add_cube to grow the body.
- Also detects wall and self collisions, and answers pixel-grid body queries for the VGA renderer.
- Grid is 40x30 cells. The border cells are walls (x=0, x=39, y=0, y=29).

Parameters:
- MAX_LEN, 16, maximum segment count; also the storage depth.
- INIT_LEN, 3, segment count after reset.
- INIT_X, 10, head x after reset.
- INIT_Y, 10, head y after reset.
- TICK_CYCLES, 250000, clk cycles per move step.
- GRID_W, 40, grid width in cells.
- GRID_H, 30, grid height in cells.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- key_up  in  1  level, direction request
- key_down  in  1  level, direction request
- key_left  in  1  level, direction request
- key_right  in  1  level, direction request
- add_cube  in  1  level from the apple stage; a rising edge means one growth
- query_x  in  6  renderer cell x
- query_y  in  6  renderer cell y
- head_x  out  6  current head cell x
- head_y  out  6  current head cell y
- body_len  out  5  current segment count, head included
- move_tick  out  1  one-cycle pulse in the cycle the snake moves
- game_over  out  1  high in DEAD state
- query_hit  out  1  query cell is a body segment (excluding head); 1-cycle latency
- query_head  out  1  query cell is the head; 1-cycle latency

Behaviour:
- Reset (reset==0 at posedge, wins over everything, including mid-move):
  - seg[i] = (INIT_X-i, INIT_Y) for i < INIT_LEN; body_len = INIT_LEN.
  - dir = RIGHT; tick counter = 0; grow_pending = 0; add_cube history = 0.
  - move_tick = 0, game_over = 0, query_hit = 0, query_head = 0; state = IDLE.
- States:
  - IDLE: any key high -> PLAY in the next cycle; the key's direction is latched (reversal rule applies).
  - PLAY: tick counter runs 0..TICK_CYCLES-1. At the wrap cycle move_tick = 1 for one cycle and a step executes.
  - DEAD: entered on collision; frozen, game_over = 1; exit only by reset.
- Direction:
  - Sampled every cycle in PLAY; priority up > down > left > right.
  - A request opposite to the direction last applied at a tick is ignored.
  - The latched direction takes effect at the next tick only.
- Step at tick:
  - Compute next head = seg[0] plus one cell in dir.
  - Collision if next head is a wall cell, or equals seg[k] for 1 <= k <= body_len-2. The upper bound becomes body_len-1 when growing this step; the vacated tail is legal when not growing.
  - On collision: state = DEAD; segments and length are unchanged.
  - Otherwise: seg[i] <= seg[i-1] for all i >= 1, and seg[0] <= next head.
  - If growing: body_len += 1, saturating at MAX_LEN. At MAX_LEN the growth is consumed with no length change.
- Growth:
  - An add_cube 0->1 edge (registered history) sets grow_pending.
  - grow_pending is consumed at the next tick.
  - If the edge and the tick occur in the same cycle, the growth applies at that tick.
  - A second edge before consumption is not double-counted.
- head_x/head_y:
  - Always equal seg[0]; they update in the cycle after move_tick.
  - The apple stage therefore sees a stable head for a full tick period.
- Query:
  - query_hit/query_head are registered from query_x/query_y, with a 1-cycle latency.
  - Only segments with index < body_len are compared.
  - Queries are valid in all states.
- Arithmetic:
  - Coordinates are 6-bit unsigned.
  - The wall check happens before any wrap, so 0-1 never occurs: head x=1 moving left reaches the x=0 wall and dies.

Decomposition:
- Shared package snake_pkg:
  - direction encoding UP/DOWN/LEFT/RIGHT (2-bit), shared with the keyboard block;
  - GRID_W, GRID_H, coordinate width 6;
  - state encoding IDLE/PLAY/DEAD.
- Sub-module snake_tick_gen: counter with a TICK_CYCLES parameter, a run enable and a move_tick pulse. It is reused by the renderer blink logic.

Test Plan:
- Reset, then sample: head=(10,10), body_len=3, seg1=(9,10), game_over=0, move_tick=0. Query (8,10) -> query_hit=1 one cycle later. Query (10,10) -> query_head=1.
- Pulse key_right, run one tick (TICK_CYCLES=4 in the bench) -> head=(11,10), seg2=(9,10); (8,10) no longer hit.
- Hold key_left while moving right -> ignored, head_x=12 after the next tick. Then key_up -> head=(12,9).
- Raise add_cube (hold high for 3 ticks) -> body_len=4 after exactly one tick, still 4 after the later ticks. An edge coincident with a tick grows at that tick.
- From head (1,10) moving left, take one tick -> game_over=1, head stays (1,10), and further ticks don't move it. Reset mid-DEAD -> IDLE, head=(10,10).
- With body_len=5, steer up, left, down -> self collision, DEAD. A length-4 loop chasing its own vacating tail does not die.
